// File: rtl/eep_cal_ctrl.sv
// Calibration EEPROM sequencer: boot-loads N_CAL bytes into cal_bank, then serves host reads/writes.
// Optional write read-back verify is enabled by defining EEP_WR_VERIFY_EN.
module eep_cal_ctrl #(
  parameter int          N_CAL   = 8,
  parameter logic [15:0] ACK_VAL = 16'hA5A5
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               spi_wrt,
  output logic [15:0]        spi_cmd,
  input  logic               spi_done,
  input  logic [15:0]        spi_rd,
  input  logic               req,
  input  logic               req_wr,
  input  logic [5:0]         req_addr,
  input  logic [7:0]         req_wdata,
  output logic               ack,
  output logic [7:0]         rdata,
  output logic               err,
  output logic               boot_done,
  output logic [8*N_CAL-1:0] cal_bank
);

  typedef enum logic [3:0] {
    BOOT_CMD, BOOT_WAIT, IDLE, H_CMD, H_WAIT, H_RSP, H_RSP_WAIT,
    V_CMD, V_WAIT, V_RSP, V_RSP_WAIT, DONE
  } state_t;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [6:0] N_CAL_W = 7'(N_CAL);

  state_t               state_q, state_d;
  logic [6:0]           cnt_q, cnt_d;
  logic                 wrt_q, wrt_d;
  logic [15:0]          cmd_q, cmd_d;
  logic                 ack_q, ack_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 boot_q, boot_d;
  logic [8*N_CAL-1:0]   bank_q, bank_d;
  logic                 hold_q, hold_d;
  logic                 lat_en;
  logic                 wr_q;
  logic [5:0]           addr_q;
  logic [7:0]           wdata_q;
  logic                 in_cal;

  function automatic logic [15:0] rd_cmd(input logic [5:0] a);
    return {OP_RD, a, 8'h00};
  endfunction

  function automatic logic [15:0] wr_cmd(input logic [5:0] a, input logic [7:0] d);
    return {OP_WR, a, d};
  endfunction

  assign in_cal = ({1'b0, addr_q} < N_CAL_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    boot_d  = boot_q;
    bank_d  = bank_q;
    hold_d  = hold_q;
    lat_en  = 1'b0;
    case (state_q)
      BOOT_CMD: begin
        // The extra last transaction only collects the previous response
        wrt_d   = 1'b1;
        cmd_d   = rd_cmd((cnt_q == N_CAL_W) ? 6'd0 : cnt_q[5:0]);
        state_d = BOOT_WAIT;
      end
      BOOT_WAIT: begin
        if (spi_done) begin
          if (cnt_q != 7'd0)
            bank_d[8*int'(cnt_q - 7'd1) +: 8] = spi_rd[7:0];
          if (cnt_q < N_CAL_W) begin
            cnt_d   = cnt_q + 7'd1;
            state_d = BOOT_CMD;
          end else begin
            cnt_d   = 7'd0;
            boot_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        // First IDLE cycle after an ack still sees the finished request's req
        if (hold_q) begin
          hold_d = 1'b0;
        end else if (req) begin
          lat_en  = 1'b1;
          state_d = H_CMD;
        end
      end
      H_CMD: begin
        wrt_d   = 1'b1;
        cmd_d   = wr_q ? wr_cmd(addr_q, wdata_q) : rd_cmd(addr_q);
        state_d = H_WAIT;
      end
      H_WAIT: begin
        if (spi_done) state_d = H_RSP;
      end
      H_RSP: begin
        wrt_d   = 1'b1;
        cmd_d   = rd_cmd(addr_q);
        state_d = H_RSP_WAIT;
      end
      H_RSP_WAIT: begin
        if (spi_done) begin
          if (!wr_q) begin
            rdata_d = spi_rd[7:0];
            err_d   = 1'b0;
            ack_d   = 1'b1;
            state_d = DONE;
          end else if (spi_rd != ACK_VAL) begin
            rdata_d = 8'h00;
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = DONE;
          end else begin
            rdata_d = 8'h00;
`ifdef EEP_WR_VERIFY_EN
            state_d = V_CMD;
`else
            err_d   = 1'b0;
            ack_d   = 1'b1;
            state_d = DONE;
            if (in_cal) bank_d[8*int'(addr_q) +: 8] = wdata_q;
`endif
          end
        end
      end
`ifdef EEP_WR_VERIFY_EN
      V_CMD: begin
        wrt_d   = 1'b1;
        cmd_d   = rd_cmd(addr_q);
        state_d = V_WAIT;
      end
      V_WAIT: begin
        if (spi_done) state_d = V_RSP;
      end
      V_RSP: begin
        wrt_d   = 1'b1;
        cmd_d   = rd_cmd(addr_q);
        state_d = V_RSP_WAIT;
      end
      V_RSP_WAIT: begin
        if (spi_done) begin
          err_d   = (spi_rd[7:0] != wdata_q);
          ack_d   = 1'b1;
          state_d = DONE;
          if (spi_rd[7:0] == wdata_q && in_cal) bank_d[8*int'(addr_q) +: 8] = wdata_q;
        end
      end
`endif
      DONE: begin
        hold_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = BOOT_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT_CMD;
      cnt_q   <= 7'd0;
      wrt_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
      boot_q  <= 1'b0;
      bank_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      boot_q  <= boot_d;
      bank_q  <= bank_d;
      hold_q  <= hold_d;
    end
  end

  // Request capture: data-only, qualified by the IDLE accept
  always_ff @(posedge clk) begin
    if (lat_en) begin
      wr_q    <= req_wr;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign spi_wrt   = wrt_q;
  assign spi_cmd   = cmd_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign boot_done = boot_q;
  assign cal_bank  = bank_q;

endmodule

// File: tb/tb_eep_cal_ctrl.sv
// Self-checking bench for eep_cal_ctrl: SPI EEPROM model plus transaction-level reference expectations.
module tb_eep_cal_ctrl;
  localparam int          N_CAL   = 8;
  localparam logic [15:0] ACK_VAL = 16'hA5A5;

  logic               clk;
  logic               rst_n;
  logic               spi_wrt;
  logic [15:0]        spi_cmd;
  logic               spi_done;
  logic [15:0]        spi_rd;
  logic               req;
  logic               req_wr;
  logic [5:0]         req_addr;
  logic [7:0]         req_wdata;
  logic               ack;
  logic [7:0]         rdata;
  logic               err;
  logic               boot_done;
  logic [8*N_CAL-1:0] cal_bank;

  eep_cal_ctrl #(.N_CAL(N_CAL), .ACK_VAL(ACK_VAL)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rd(spi_rd),
    .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .err(err), .boot_done(boot_done), .cal_bank(cal_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // EEPROM contents and reference state
  logic [7:0]  mem [64];
  logic [7:0]  exp_bank [N_CAL];
  logic [15:0] prev_resp;
  logic [15:0] cur_cmd;
  logic [15:0] cmd_log [$];
  bit          force_nak;
  bit          busy;
  int          dly;
  int          wrt_cnt;
  int          done_cnt;
  int          ack_cnt;

  task automatic execute(input logic [15:0] c);
    if (c[15:14] == 2'b00) begin
      prev_resp = {8'h00, mem[c[13:8]]};
    end else if (c[15:14] == 2'b01) begin
      if (force_nak) prev_resp = 16'h0000;
      else begin
        mem[c[13:8]] = c[7:0];
        prev_resp    = ACK_VAL;
      end
    end else begin
      prev_resp = 16'hFFFF;
    end
  endtask

  // SPI master + EEPROM: answers each transaction with the previous command's response
  initial begin
    busy = 0; spi_done = 1'b0; spi_rd = 16'h0000; prev_resp = 16'h0000;
    cur_cmd = 16'h0000; dly = 0;
    forever begin
      @(posedge clk); #1;
      spi_done = 1'b0;
      if (!rst_n) begin
        busy = 0;
        continue;
      end
      if (busy) begin
        chk("one_outstanding", spi_wrt, 1'b0);
        chk("cmd_stable", spi_cmd, cur_cmd);
        if (dly == 0) begin
          spi_rd   = prev_resp;
          spi_done = 1'b1;
          busy     = 0;
          done_cnt++;
          execute(cur_cmd);
        end else begin
          dly--;
        end
      end else if (spi_wrt) begin
        busy    = 1;
        cur_cmd = spi_cmd;
        dly     = $urandom_range(0, 3);
        cmd_log.push_back(spi_cmd);
        wrt_cnt++;
      end
    end
  end

  always @(negedge clk) if (ack) ack_cnt++;

  function automatic logic [63:0] pack_bank();
    logic [63:0] p;
    p = '0;
    for (int k = 0; k < N_CAL; k++) p[8*k +: 8] = exp_bank[k];
    return p;
  endfunction

  task automatic boot_seq(output logic [15:0] q [$]);
    q = {};
    for (int k = 0; k < N_CAL; k++) q.push_back({2'b00, 6'(k), 8'h00});
    q.push_back(16'h0000);
  endtask

  task automatic check_log(input string tag, input logic [15:0] exp [$]);
    int n;
    chk({tag, "_len"}, cmd_log.size(), exp.size());
    n = (cmd_log.size() < exp.size()) ? cmd_log.size() : exp.size();
    for (int i = 0; i < n; i++) chk({tag, "_cmd"}, cmd_log[i], exp[i]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0; req_wr = 1'b0; req_addr = 6'd0; req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {spi_wrt, spi_cmd, ack, rdata, err, boot_done}, 0);
    chk("rst_bank", cal_bank, 0);
    cmd_log.delete(); wrt_cnt = 0; done_cnt = 0; ack_cnt = 0; force_nak = 0;
    rst_n = 1'b1;
  endtask

  // Waits for boot completion, then checks the load sequence and bank contents
  task automatic wait_and_check_boot(input string tag);
    logic [15:0] exp [$];
    for (int i = 0; i < 3000 && !boot_done; i++) @(negedge clk);
    chk({tag, "_boot_done"}, boot_done, 1'b1);
    chk({tag, "_wrt_cnt"}, wrt_cnt, N_CAL + 1);
    chk({tag, "_done_cnt"}, done_cnt, N_CAL + 1);
    boot_seq(exp);
    check_log(tag, exp);
    for (int k = 0; k < N_CAL; k++) exp_bank[k] = mem[k];
    chk({tag, "_bank"}, cal_bank, pack_bank());
  endtask

  task automatic do_req(input bit wr, input logic [5:0] a, input logic [7:0] d, input bit nak);
    logic [15:0] exp [$];
    logic [7:0]  exp_rd;
    bit          exp_err;
    bit          seen;
    logic [7:0]  got_rd;
    logic        got_err;
    int          acks0;
    exp_rd  = wr ? 8'h00 : mem[a];
    exp_err = wr && nak;
    exp = {};
    if (wr) begin
      exp.push_back({2'b01, a, d});
      exp.push_back({2'b00, a, 8'h00});
`ifdef EEP_WR_VERIFY_EN
      if (!nak) begin
        exp.push_back({2'b00, a, 8'h00});
        exp.push_back({2'b00, a, 8'h00});
      end
`endif
      if (!nak && a < N_CAL) exp_bank[a] = d;
    end else begin
      exp.push_back({2'b00, a, 8'h00});
      exp.push_back({2'b00, a, 8'h00});
    end
    force_nak = nak;
    cmd_log.delete();
    acks0 = ack_cnt;
    @(negedge clk);
    req = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    seen = 0; got_rd = 8'h00; got_err = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1; got_rd = rdata; got_err = err;
      end
    end
    req = 1'b0;
    chk("ack_seen", seen, 1'b1);
    chk(wr ? "wr_err" : "rd_err", got_err, exp_err);
    if (!wr) chk("rd_data", got_rd, exp_rd);
    repeat (6) @(negedge clk);
    chk("ack_once", ack_cnt - acks0, 1);
    check_log(wr ? "wr" : "rd", exp);
    chk("bank_after_req", cal_bank, pack_bank());
    force_nak = 0;
  endtask

  initial begin
    logic [15:0] exp [$];
    bit          seen;
    bit          bd_at_ack;
    logic [7:0]  got_rd;
    rst_n = 1'b0;
    req = 1'b0; req_wr = 1'b0; req_addr = 6'd0; req_wdata = 8'h00;
    force_nak = 0; wrt_cnt = 0; done_cnt = 0; ack_cnt = 0;
    for (int k = 0; k < 64; k++) mem[k] = (k < 8) ? 8'(8'h11 * (k + 1)) : 8'($urandom);

    // Boot from preloaded 11..88
    apply_reset();
    wait_and_check_boot("boot0");
    chk("boot0_bank_const", cal_bank, 64'h8877665544332211);

    // Directed host transactions
    do_req(1'b0, 6'h05, 8'h00, 1'b0);
    do_req(1'b1, 6'h03, 8'h5A, 1'b0);
    chk("byte3", cal_bank[31:24], 8'h5A);
    do_req(1'b1, 6'h04, 8'h3C, 1'b1);
    do_req(1'b1, 6'h2A, 8'hC3, 1'b0);

    // Randomized host traffic
    for (int n = 0; n < 24; n++) begin
      bit          wr;
      logic [5:0]  a;
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, N_CAL - 1)) : 6'($urandom);
      do_req(wr, a, 8'($urandom), wr && ($urandom_range(0, 3) == 0));
    end

    // Reset during the 4th boot transaction
    apply_reset();
    for (int i = 0; i < 500 && wrt_cnt < 4; i++) @(negedge clk);
    chk("mid_boot_reach4", wrt_cnt, 4);
    @(negedge clk);
    apply_reset();
    wait_and_check_boot("reboot");
    do_req(1'b0, 6'h01, 8'h00, 1'b0);

    // Request held through boot: served exactly once, only after boot_done
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmd_log.delete(); wrt_cnt = 0; done_cnt = 0; ack_cnt = 0;
    req = 1'b1; req_wr = 1'b0; req_addr = 6'h02; req_wdata = 8'h00;
    rst_n = 1'b1;
    seen = 0; bd_at_ack = 0; got_rd = 8'h00;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1; bd_at_ack = boot_done; got_rd = rdata;
      end
    end
    req = 1'b0;
    chk("held_ack_seen", seen, 1'b1);
    chk("held_boot_done_at_ack", bd_at_ack, 1'b1);
    chk("held_rdata", got_rd, mem[2]);
    boot_seq(exp);
    exp.push_back(16'h0200);
    exp.push_back(16'h0200);
    check_log("held", exp);
    repeat (6) @(negedge clk);
    chk("held_ack_once", ack_cnt, 1);
    for (int k = 0; k < N_CAL; k++) exp_bank[k] = mem[k];
    chk("held_bank", cal_bank, pack_bank());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
